// File: rtl/booth_multiplier_16bit.sv
// ---------------------------------------------------------------------------
// booth_multiplier_16bit
//
// Sequential signed radix-2 Booth multiplier. Two two's-complement operands
// are captured on an accepted start pulse and one Booth step is performed per
// clock. After WIDTH steps the full 2*WIDTH-bit product is registered and a
// single-cycle done strobe is raised.
//
// Ports:
//   clk      in   1          rising-edge clock
//   rst      in   1          synchronous active-high reset
//   start    in   1          request, honoured only in IDLE or DONE
//   in0      in   WIDTH      signed multiplicand, captured on accepted start
//   in1      in   WIDTH      signed multiplier, captured on accepted start
//   busy     out  1          high while iterating
//   done     out  1          one-cycle strobe, product valid
//   product  out  2*WIDTH    signed in0*in1, held until next completion
// ---------------------------------------------------------------------------
module booth_multiplier_16bit #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in0,
    input  logic [WIDTH-1:0]     in1,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Booth step intermediates
    logic [WIDTH:0]       step_sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;

    // Add/subtract with optional invert: a + b, or a + ~b + 1 when sub is set.
    function automatic logic [WIDTH:0] addsub(
        input logic [WIDTH:0] a,
        input logic [WIDTH:0] b,
        input logic           sub
    );
        logic [WIDTH:0] b_x;
        b_x = sub ? ~b : b;
        return a + b_x + {{WIDTH{1'b0}}, sub};
    endfunction

    // Booth step datapath: conditional add/sub followed by arithmetic shift.
    always_comb begin
        step_sum = a_q;
        case ({q_q[0], qm1_q})
            2'b01:   step_sum = addsub(a_q, m_q, 1'b0);
            2'b10:   step_sum = addsub(a_q, m_q, 1'b1);
            default: step_sum = a_q;
        endcase
        // The shift replicates A's MSB; the extra accumulator bit keeps the
        // sign correct even for M = -2^(WIDTH-1).
        a_shift = {step_sum[WIDTH], step_sum[WIDTH:1]};
        q_shift = {step_sum[0], q_q[WIDTH-1:1]};
    end

    // Next-state and next-register computation for the control FSM.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    m_d     = {in0[WIDTH-1], in0};
                    a_d     = {(WIDTH+1){1'b0}};
                    q_d     = in1;
                    qm1_d   = 1'b0;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                a_d   = a_shift;
                q_d   = q_shift;
                qm1_d = q_q[0];
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_STEP) begin
                    // Final step: the shifted {A,Q} already holds the product.
                    product_d = {a_shift[WIDTH-1:0], q_shift};
                    state_d   = ST_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    state_d   = ST_RUN;
                    busy_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= {(WIDTH+1){1'b0}};
            m_q       <= {(WIDTH+1){1'b0}};
            q_q       <= {WIDTH{1'b0}};
            qm1_q     <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= {(2*WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_multiplier_16bit.sv
// ---------------------------------------------------------------------------
// tb_booth_multiplier_16bit
//
// Directed testbench for booth_multiplier_16bit with hand-computed products.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_booth_multiplier_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int errors;
    logic [31:0] last_product;

    booth_multiplier_16bit #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in0     (in0),
        .in1     (in1),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full operation from IDLE: start in cycle 0, verify busy/done/product
    // timing through cycle 17, then one idle cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
        start = 1'b1;
        in0   = a;
        in1   = b;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
            check({tag, "_done_run"}, {31'd0, done}, 32'd0);
            check({tag, "_prod_hold"}, product, last_product);
            tick();
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_product"}, product, exp);
        last_product = exp;
        tick();
        check({tag, "_done_after"}, {31'd0, done}, 32'd0);
        check({tag, "_prod_after"}, product, exp);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        last_product = 32'h0000_0000;
        rst   = 1'b1;
        start = 1'b0;
        in0   = 16'h0000;
        in1   = 16'h0000;
        tick();
        tick();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_product", product, 32'h0000_0000);
        rst = 1'b0;
        tick();

        // 3 x 5, product held 10 more cycles
        run_op(16'd3, 16'd5, 32'h0000_000F, "mul_3x5");
        for (int c = 0; c < 9; c++) begin
            check("hold_3x5_done", {31'd0, done}, 32'd0);
            check("hold_3x5_prod", product, 32'h0000_000F);
            tick();
        end

        // Signed patterns and the most-negative operand
        run_op(16'hFFF9, 16'd6, 32'hFFFF_FFD6, "mul_m7x6");
        run_op(16'h7FFF, 16'h8000, 32'hC000_8000, "mul_max_min");
        run_op(16'h8000, 16'h8000, 32'h4000_0000, "mul_min_min");
        run_op(16'h0000, 16'h1234, 32'h0000_0000, "mul_zero");

        // start during RUN ignored, operands free to change after accept
        start = 1'b1;
        in0   = 16'd3;
        in1   = 16'd5;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            start = (c == 5) ? 1'b1 : 1'b0;
            in0   = (c == 5) ? 16'd100 : 16'(c * 7 + 1);
            in1   = (c == 5) ? 16'd100 : 16'(16'hA000 + c);
            check("ign_done_run", {31'd0, done}, 32'd0);
            check("ign_busy_run", {31'd0, busy}, 32'd1);
            tick();
        end
        start = 1'b0;
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_product", product, 32'h0000_000F);
        last_product = 32'h0000_000F;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("ign_no_second_done", {31'd0, done}, 32'd0);
            check("ign_prod_hold", product, 32'h0000_000F);
        end

        // Back-to-back: start in the DONE cycle
        start = 1'b1;
        in0   = 16'd3;
        in1   = 16'd5;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
        end
        check("b2b_first_done", {31'd0, done}, 32'd1);
        check("b2b_first_prod", product, 32'h0000_000F);
        start = 1'b1;
        in0   = 16'hFFFE;
        in1   = 16'hFFFE;
        tick();
        start = 1'b0;
        for (int c = 18; c <= 33; c++) begin
            check("b2b_busy", {31'd0, busy}, 32'd1);
            check("b2b_done_run", {31'd0, done}, 32'd0);
            check("b2b_prod_hold", product, 32'h0000_000F);
            tick();
        end
        check("b2b_second_done", {31'd0, done}, 32'd1);
        check("b2b_second_prod", product, 32'h0000_0004);
        last_product = 32'h0000_0004;
        tick();
        check("b2b_done_single", {31'd0, done}, 32'd0);

        // Reset mid-RUN discards the operation
        run_op(16'd3, 16'd5, 32'h0000_000F, "pre_abort");
        start = 1'b1;
        in0   = 16'd9;
        in1   = 16'd9;
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            tick();
        end
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", product, 32'h0000_0000);
        last_product = 32'h0000_0000;
        for (int c = 0; c < 30; c++) begin
            tick();
            check("abort_no_done", {31'd0, done}, 32'd0);
            check("abort_idle_busy", {31'd0, busy}, 32'd0);
            check("abort_prod_zero", product, 32'h0000_0000);
        end
        run_op(16'd9, 16'd9, 32'h0000_0051, "mul_9x9");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
